fetch: RTL

In-order instruction fetch stage feeding `dispatch`. Owns the architectural fetch PC, issues one request at a time to instruction memory, and predecodes B/BL to redirect the PC speculatively. Delivers each fetched word with its PC through a registered one-cycle `done` pulse. Halts on HLT and accepts redirects from commit.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_predict_next_pc.sv | 23 ++
 rtl/fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   GPR_SIZE / INSNBITS_SIZE : datapath widths (PC and instruction word)
//   fetch_state_t            : fetch FSM states
//   OP_* constants           : B/BL/HLT match/mask values, shared with the decoder
package fetch_pkg;
  localparam int GPR_SIZE      = 64;
  localparam int INSNBITS_SIZE = 32;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_HALT
  } fetch_state_t;

  // B and BL differ only in bit 31; both carry imm26 in bits [25:0].
  localparam logic [INSNBITS_SIZE-1:0] OP_B_MASK    = 32'hFC00_0000;
  localparam logic [INSNBITS_SIZE-1:0] OP_B_MATCH   = 32'h1400_0000;
  localparam logic [INSNBITS_SIZE-1:0] OP_BL_MATCH  = 32'h9400_0000;
  // HLT #imm16: imm16 in bits [20:5] is don't-care.
  localparam logic [INSNBITS_SIZE-1:0] OP_HLT_MASK  = 32'hFFE0_001F;
  localparam logic [INSNBITS_SIZE-1:0] OP_HLT_MATCH = 32'hD440_0000;
endpackage

// File: rtl/fetch_predict_next_pc.sv
// predict_next_pc: combinational predecode of one fetched word.
//   pc_i       : PC of the word
//   insnbits_i : instruction word
//   next_pc_o  : PC + sext(imm26)<<2 for B/BL, PC + 4 otherwise (mod 2^64)
//   is_hlt_o   : word is HLT
module predict_next_pc
  import fetch_pkg::*;
(
  input  logic [GPR_SIZE-1:0]      pc_i,
  input  logic [INSNBITS_SIZE-1:0] insnbits_i,
  output logic [GPR_SIZE-1:0]      next_pc_o,
  output logic                     is_hlt_o
);
  logic                is_b;
  logic [GPR_SIZE-1:0] offset;

  assign is_b = ((insnbits_i & OP_B_MASK) == OP_B_MATCH) ||
                ((insnbits_i & OP_B_MASK) == OP_BL_MATCH);
  // Sign-extend imm26 first, then scale by 4 (append two zeros).
  assign offset    = {{(GPR_SIZE-28){insnbits_i[25]}}, insnbits_i[25:0], 2'b00};
  assign next_pc_o = pc_i + (is_b ? offset : GPR_SIZE'(4));
  assign is_hlt_o  = (insnbits_i & OP_HLT_MASK) == OP_HLT_MATCH;
endmodule

// File: rtl/fetch.sv
// fetch: in-order instruction fetch stage feeding dispatch.
//   in_clk, in_rst          : clock, synchronous active-high reset
//   in_stall                : dispatch cannot accept a word
//   in_redirect(_PC)        : commit-side PC redirect
//   out_imem_req/_addr      : one-cycle request pulse to instruction memory
//   in_imem_valid/_rdata    : memory response (>=1 cycle after request)
//   out_reg_insnbits/_branch_PC/_done : delivered word, its PC, one-cycle pulse
//   out_reg_halted          : high while halted on HLT
module fetch
  import fetch_pkg::*;
#(
  parameter logic [GPR_SIZE-1:0] RESET_PC = 64'h0
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic                     in_stall,
  input  logic                     in_redirect,
  input  logic [GPR_SIZE-1:0]      in_redirect_PC,
  output logic                     out_imem_req,
  output logic [GPR_SIZE-1:0]      out_imem_addr,
  input  logic                     in_imem_valid,
  input  logic [INSNBITS_SIZE-1:0] in_imem_rdata,
  output logic [INSNBITS_SIZE-1:0] out_reg_insnbits,
  output logic                     out_reg_done,
  output logic [GPR_SIZE-1:0]      out_reg_branch_PC,
  output logic                     out_reg_halted
);
  fetch_state_t             state_q;
  logic [GPR_SIZE-1:0]      pc_q;
  logic                     drop_q;
  logic                     req_q;
  logic [GPR_SIZE-1:0]      addr_q;
  logic                     done_q;
  logic [INSNBITS_SIZE-1:0] insn_q;
  logic [GPR_SIZE-1:0]      bpc_q;
  logic                     halted_q;

  logic [INSNBITS_SIZE-1:0] pred_insn;
  logic [GPR_SIZE-1:0]      pred_npc;
  logic                     pred_hlt;
  logic                     outstanding;

  // In HOLD the word lives in insn_q; only its HLT flag is needed there.
  assign pred_insn = (state_q == FETCH_HOLD) ? insn_q : in_imem_rdata;

  predict_next_pc u_pred (
    .pc_i       (pc_q),
    .insnbits_i (pred_insn),
    .next_pc_o  (pred_npc),
    .is_hlt_o   (pred_hlt)
  );

  // A response arriving this very cycle no longer counts as outstanding.
  assign outstanding = (state_q == FETCH_WAIT) && !in_imem_valid;

  // "Go to REQ" after a response/redirect registers the request directly so
  // it appears in the same cycle as done (throughput L+1). FETCH_REQ itself
  // is only visited out of reset.
  always_ff @(posedge in_clk) begin
    req_q  <= 1'b0;
    done_q <= 1'b0;
    if (in_rst) begin
      state_q  <= FETCH_REQ;
      pc_q     <= RESET_PC;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      insn_q   <= '0;
      bpc_q    <= '0;
      halted_q <= 1'b0;
    end else if (in_redirect) begin
      pc_q     <= in_redirect_PC;
      halted_q <= 1'b0;
      state_q  <= FETCH_WAIT;
      if (outstanding) begin
        drop_q <= 1'b1;
      end else begin
        drop_q <= 1'b0;
        req_q  <= 1'b1;
        addr_q <= in_redirect_PC;
      end
    end else begin
      case (state_q)
        FETCH_REQ: begin
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          state_q <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (in_imem_valid) begin
            if (drop_q) begin
              // Stale response from before a redirect; pc_q is already the target.
              drop_q <= 1'b0;
              req_q  <= 1'b1;
              addr_q <= pc_q;
            end else begin
              insn_q <= in_imem_rdata;
              bpc_q  <= pc_q;
              pc_q   <= pred_npc;
              if (in_stall) begin
                state_q <= FETCH_HOLD;
              end else begin
                done_q <= 1'b1;
                if (pred_hlt) begin
                  state_q  <= FETCH_HALT;
                  halted_q <= 1'b1;
                end else begin
                  req_q  <= 1'b1;
                  addr_q <= pred_npc;
                end
              end
            end
          end
        end
        FETCH_HOLD: begin
          if (!in_stall) begin
            done_q <= 1'b1;
            if (pred_hlt) begin
              state_q  <= FETCH_HALT;
              halted_q <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= pc_q;
              state_q <= FETCH_WAIT;
            end
          end
        end
        FETCH_HALT: ;
        default: state_q <= FETCH_REQ;
      endcase
    end
  end

  assign out_imem_req      = req_q;
  assign out_imem_addr     = addr_q;
  assign out_reg_done      = done_q;
  assign out_reg_insnbits  = insn_q;
  assign out_reg_branch_PC = bpc_q;
  assign out_reg_halted    = halted_q;
endmodule
